sv_range_check_arbiter: RTL
===========================

Name: sv_range_check_arbiter

Overview:
Shares one 4-bit range-classification datapath between NUM_REQ requesters. Data in [3:7] sets flag 0, data in {2,5,9} sets flag 1, data in [10:15] sets flag 2. A round-robin arbiter grants one requester at a time and captures that requester's 4-bit sample. A three-state sequencer evaluates the sample and returns a tagged result. Per-range saturating hit counters give software-visible statistics. The block sits between the sample producers and the status/CSR logic.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 8, width of each hit counter
ID_W, $clog2(NUM_REQ), width of the requester id (derived, not overridden)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request; held high until granted
req_data  input  NUM_REQ*4  packed samples; requester i uses bits [4i+3:4i]
gnt  output  NUM_REQ  one-hot grant, one-cycle pulse
rsp_valid  output  1  result-valid pulse
rsp_id  output  ID_W  index of the requester the result belongs to
rsp_flags  output  3  {in_range3, in_range2, in_range1} for the captured sample
cnt_clr  input  1  synchronous clear of all hit counters
cnt_r1  output  CNT_W  count of samples with flag 0 set
cnt_r2  output  CNT_W  count of samples with flag 1 set
cnt_r3  output  CNT_W  count of samples with flag 2 set

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr_ptr=0. gnt, rsp_valid, rsp_id, rsp_flags, data_q, id_q and all counters clear to 0.
- Reset takes effect in any state. An in-flight transaction is dropped and no rsp_valid is issued for it.
- All outputs are registered.
- FSM has three states: IDLE, EVAL, RESP.
- IDLE with req==0: stay in IDLE; gnt=0.
- IDLE with req!=0, at the clock edge:
  - winner = first set bit of req, searching upward from rr_ptr with wrap modulo NUM_REQ.
  - data_q <= req_data slice of the winner; id_q <= winner.
  - gnt <= one-hot(winner); rr_ptr <= (winner+1) mod NUM_REQ; go to EVAL.
- EVAL (gnt high for exactly this cycle):
  - Flags are computed from data_q.
  - At the edge: rsp_flags <= flags; rsp_id <= id_q; rsp_valid <= 1; gnt <= 0.
  - Counters increment per set flag; go to RESP.
- RESP (rsp_valid high for exactly this cycle; counters already reflect the sample):
  - At the edge: rsp_valid <= 0; go to IDLE.
  - rsp_flags and rsp_id hold their values until the next EVAL.
- Timing: req sampled at edge N → gnt high in cycle N+1 → rsp_valid high in cycle N+2 → next grant can be sampled at edge N+3. Peak rate is one transaction per 3 cycles.
- req is ignored in EVAL and RESP. A granted requester deasserts req at the edge ending its gnt cycle; if it keeps req high, it is treated as a new request.
- req_data of a requester must be stable while its req is high. Only the value sampled at the grant edge is used.
- Flags are not exclusive: data 5 sets flags 0 and 1. Data 0, 1, 8 produce flags 000.
- Counters:
  - Each counter saturates at 2^CNT_W-1; no wrap.
  - cnt_clr clears all three counters at the next edge.
  - cnt_clr has priority over a simultaneous increment; that sample is not counted.
  - cnt_clr does not affect the FSM, rr_ptr or rsp_* outputs.
- Requests that arrive while busy are not lost: they stay pending on req and are arbitrated on the next IDLE cycle.

Test Plan:
- Reset check: drive rst_n=0 with random req → gnt=0, rsp_valid=0, rsp_id=0, rsp_flags=0, all counters 0. After release with req=0 the FSM stays IDLE.
- Single request: req=0100, req_data slice2=5 → gnt=0100 one cycle later, then rsp_valid=1 with rsp_id=2, rsp_flags=011; cnt_r1=1, cnt_r2=1, cnt_r3=0.
- Round robin: all four requests held continuously with data 0, 9, 12, 7 →
  - grant order 0,1,2,3,0 with one grant every 3 cycles;
  - rsp_flags 000, 010, 100, 001;
  - after four results cnt_r1=1, cnt_r2=1, cnt_r3=1.
- Full sweep: requester 1 sends data 0..15 → flags match [3:7] / {2,5,9} / [10:15] for every value; final counts cnt_r1=5, cnt_r2=3, cnt_r3=6.
- Saturation and clear (CNT_W=2): five samples of data 4 → cnt_r1 goes 1,2,3,3,3. Then assert cnt_clr in the same cycle as an EVAL for data 4 → cnt_r1=0 afterwards.
- Reset mid-operation: pull rst_n low during EVAL → no rsp_valid, gnt drops immediately, rr_ptr=0. After release, req=1111 is granted to requester 0 first.

Source files
------------

// File: rtl/sv_range_check_arbiter.sv
// -----------------------------------------------------------------------------
// sv_range_check_arbiter
//
// Shares one 4-bit range classifier between NUM_REQ requesters. A round-robin
// arbiter picks one pending requester, captures its sample, and a three-state
// sequencer (IDLE -> EVAL -> RESP) returns the classification tagged with the
// requester id. Three saturating hit counters track how many samples fell in
// each range.
//
// Range flags for a sample d:
//   flag 0 : 3 <= d <= 7
//   flag 1 : d in {2, 5, 9}
//   flag 2 : 10 <= d <= 15
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester request, held until granted
//   req_data   packed samples, requester i on bits [4i+3:4i]
//   gnt        one-hot grant, one-cycle pulse (high during EVAL)
//   rsp_valid  result-valid pulse (high during RESP)
//   rsp_id     requester index of the result
//   rsp_flags  {flag2, flag1, flag0} of the captured sample
//   cnt_clr    synchronous clear of all hit counters
//   cnt_r1..3  saturating hit counters for flags 0..2
// -----------------------------------------------------------------------------
module sv_range_check_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*4-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2:0]             rsp_flags,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       cnt_r1,
    output logic [CNT_W-1:0]       cnt_r2,
    output logic [CNT_W-1:0]       cnt_r3
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Classify a 4-bit sample into the three (non-exclusive) range flags.
    function automatic logic [2:0] classify(input logic [3:0] d);
        logic r1;
        logic r2;
        logic r3;
        r1 = (d >= 4'd3) && (d <= 4'd7);
        r2 = (d == 4'd2) || (d == 4'd5) || (d == 4'd9);
        r3 = (d >= 4'd10);
        return {r3, r2, r1};
    endfunction

    // Increment a counter by one when enabled, holding at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic             en);
        logic [CNT_W-1:0] res;
        if (en && (c != {CNT_W{1'b1}})) begin
            res = c + CNT_W'(1'b1);
        end else begin
            res = c;
        end
        return res;
    endfunction

    state_t                 state_r;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [3:0]             data_q_r;
    logic [ID_W-1:0]        id_q_r;

    logic [2*NUM_REQ-1:0]   req2_s;
    logic                   found_s;
    logic [ID_W-1:0]        offset_s;
    logic [ID_W:0]          sum_s;
    logic [ID_W-1:0]        winner_s;
    logic [ID_W-1:0]        nxt_ptr_s;
    logic [3:0]             sample_s;
    logic [NUM_REQ-1:0]     gnt_nxt_s;
    logic [2:0]             eval_flags_s;

    // Rotate the request vector so bit k is requester (rr_ptr + k) mod NUM_REQ;
    // the first set bit from the bottom is then the round-robin winner.
    assign req2_s = {req, req} >> rr_ptr_r;

    // Find the lowest set bit of the rotated requests.
    always_comb begin
        found_s  = 1'b0;
        offset_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && req2_s[k]) begin
                found_s  = 1'b1;
                offset_s = ID_W'(k);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Map the rotated offset back to an absolute requester index and derive
    // the pointer that starts the next search just past the winner.
    always_comb begin
        sum_s = {1'b0, rr_ptr_r} + {1'b0, offset_s};
        if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
            winner_s = ID_W'(sum_s - (ID_W+1)'(NUM_REQ));
        end else begin
            winner_s = sum_s[ID_W-1:0];
        end
        if (winner_s == ID_W'(NUM_REQ - 1)) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = winner_s + ID_W'(1'b1);
        end
        gnt_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
    end

    // Select the winner's 4-bit sample out of the packed data bus.
    always_comb begin
        sample_s = 4'h0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner_s == ID_W'(k)) begin
                sample_s = req_data[4*k +: 4];
            end else begin
                sample_s = sample_s;
            end
        end
    end

    assign eval_flags_s = classify(data_q_r);

    // Sequencer: arbitrate in IDLE, publish the result in EVAL, pulse in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            data_q_r  <= 4'h0;
            id_q_r    <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_flags <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (found_s) begin
                        data_q_r <= sample_s;
                        id_q_r   <= winner_s;
                        gnt      <= gnt_nxt_s;
                        rr_ptr_r <= nxt_ptr_s;
                        state_r  <= ST_EVAL;
                    end else begin
                        gnt      <= '0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    rsp_flags <= eval_flags_s;
                    rsp_id    <= id_q_r;
                    rsp_valid <= 1'b1;
                    gnt       <= '0;
                    state_r   <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    gnt       <= '0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    gnt       <= '0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Hit counters: clear wins over a same-cycle increment from EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r1 <= '0;
            cnt_r2 <= '0;
            cnt_r3 <= '0;
        end else if (cnt_clr) begin
            cnt_r1 <= '0;
            cnt_r2 <= '0;
            cnt_r3 <= '0;
        end else if (state_r == ST_EVAL) begin
            cnt_r1 <= sat_inc(cnt_r1, eval_flags_s[0]);
            cnt_r2 <= sat_inc(cnt_r2, eval_flags_s[1]);
            cnt_r3 <= sat_inc(cnt_r3, eval_flags_s[2]);
        end else begin
            cnt_r1 <= cnt_r1;
            cnt_r2 <= cnt_r2;
            cnt_r3 <= cnt_r3;
        end
    end

endmodule
